// File: rtl/nand3_bist.sv
// rtl/nand3_bist.sv - exhaustive 8-vector BIST sequencer for a 3-input NAND cell
// Optional response MISR on SIG is enabled by defining NAND3_BIST_MISR_EN.

module nand3_bist #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       START,
  output logic       DUT_A,
  output logic       DUT_B,
  output logic       DUT_C,
  input  logic       DUT_Y,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [2:0] FIRST_FAIL,
  output logic [7:0] SIG
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_INIT = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [2:0] v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [2:0] ff_q, ff_d;
  logic       mismatch;

  // Only the all-ones vector should pull a good NAND3 output low.
  assign mismatch = (DUT_Y != ~(&v_q));

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = DRIVE;
          v_d     = 3'd0;
          err_d   = 4'd0;
          ff_d    = 3'd0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (SETTLE_CYC == 0) begin
          state_d = SAMPLE;
        end else begin
          state_d = SETTLE;
          cnt_d   = SETTLE_INIT;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (err_q == 4'd0) begin
            ff_d = v_q;
          end
        end
        if (v_q == 3'd7) begin
          state_d = FIN;
          pass_d  = (err_q == 4'd0) && !mismatch;
        end else begin
          state_d = DRIVE;
          v_d     = v_q + 3'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      v_q     <= 3'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      ff_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

`ifdef NAND3_BIST_MISR_EN
  logic [7:0] sig_q, sig_d;
  logic       fb;

  always_comb begin
    fb    = sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3];
    sig_d = sig_q;
    if (state_q == IDLE && START) begin
      sig_d = 8'hFF;
    end else if (state_q == SAMPLE) begin
      sig_d = {sig_q[6:0], fb ^ DUT_Y};
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      sig_q <= 8'h00;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign SIG = sig_q;
`else
  assign SIG = 8'h00;
`endif

  // The stimulus lines are the vector register itself, so they hold the last vector when idle.
  assign {DUT_A, DUT_B, DUT_C} = v_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign ERR_CNT    = err_q;
  assign FIRST_FAIL = ff_q;

endmodule

// File: tb/tb_nand3_bist.sv
// tb/tb_nand3_bist.sv - scoreboard bench for nand3_bist (SETTLE_CYC=2 and SETTLE_CYC=0 instances)
// Expected SIG follows NAND3_BIST_MISR_EN.

module tb_nand3_bist;

  logic       clk = 1'b0;
  logic       r;
  logic       start, start0;
  logic       a, b, c, y, busy, done, pass;
  logic [3:0] err;
  logic [2:0] ff;
  logic [7:0] sig;
  logic       a0, b0, c0, y0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [2:0] ff0;
  logic [7:0] sig0;
  int         mode = 0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_done = 0;

  typedef struct {
    int pass;
    int err;
    int ff;
    int sig;
    int start;
    int lat;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];
  exp_t m_e, m_e0, last_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cell under test: 0 = good NAND3, 1 = Y stuck-at-1, 2 = Y stuck-at-0
  assign y  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ~(a & b & c);
  assign y0 = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ~(a0 & b0 & c0);

  nand3_bist #(.SETTLE_CYC(2)) u_dut (
    .CLK(clk), .R(r), .START(start),
    .DUT_A(a), .DUT_B(b), .DUT_C(c), .DUT_Y(y),
    .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_CNT(err), .FIRST_FAIL(ff), .SIG(sig)
  );

  nand3_bist #(.SETTLE_CYC(0)) u_dut0 (
    .CLK(clk), .R(r), .START(start0),
    .DUT_A(a0), .DUT_B(b0), .DUT_C(c0), .DUT_Y(y0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0),
    .ERR_CNT(err0), .FIRST_FAIL(ff0), .SIG(sig0)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int sig_exp(input int m);
`ifdef NAND3_BIST_MISR_EN
    if (m == 0) return 8'hFE;
    if (m == 1) return 8'hFF;
    return 8'h0B;
`else
    return 0;
`endif
  endfunction

  function automatic exp_t mk(input int m, input int st, input int lat);
    exp_t e;
    e.pass  = (m == 0) ? 1 : 0;
    e.err   = (m == 0) ? 0 : (m == 1) ? 1 : 7;
    e.ff    = (m == 1) ? 7 : 0;
    e.sig   = sig_exp(m);
    e.start = st;
    e.lat   = lat;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      chk("done_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        m_e = q.pop_front();
        chk("latency", cyc - m_e.start, m_e.lat);
        chk("pass", int'(pass), m_e.pass);
        chk("err_cnt", int'(err), m_e.err);
        chk("first_fail", int'(ff), m_e.ff);
        chk("sig", int'(sig), m_e.sig);
        chk("busy_in_fin", int'(busy), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      chk("done0_expected", int'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        m_e0 = q0.pop_front();
        chk("latency0", cyc - m_e0.start, m_e0.lat);
        chk("pass0", int'(pass0), m_e0.pass);
        chk("err_cnt0", int'(err0), m_e0.err);
        chk("first_fail0", int'(ff0), m_e0.ff);
        chk("sig0", int'(sig0), m_e0.sig);
      end
    end
  end

  task automatic wait_done(input int which, input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0) ? (done === 1'b1) : (done0 === 1'b1)) begin
        got = 1;
        break;
      end
    end
    chk("done_timeout", got, 1);
  endtask

  task automatic run_main(input int m);
    mode = m;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    last_e = mk(m, cyc, 32);
    q.push_back(last_e);
    @(negedge clk) start = 1'b0;
    wait_done(0, 100);
    repeat (3) @(negedge clk);
    chk("hold_pass", int'(pass), last_e.pass);
    chk("hold_err", int'(err), last_e.err);
    chk("hold_ff", int'(ff), last_e.ff);
    chk("hold_sig", int'(sig), last_e.sig);
    chk("hold_abc", int'({a, b, c}), 7);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int d_before;
    r = 1'b0;
    start = 1'b0;
    start0 = 1'b0;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ff", int'(ff), 0);
    chk("rst_sig", int'(sig), 0);
    chk("rst_abc", int'({a, b, c}), 0);
    repeat (2) @(negedge clk);
    r = 1'b1;

    run_main(0);
    run_main(1);
    run_main(2);

    // Reset in the first SETTLE cycle of vector 4
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(mk(0, cyc, 32));
    @(negedge clk) start = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort_vec", int'({a, b, c}), 4);
    chk("abort_busy_before", int'(busy), 1);
    r = 1'b0;
    q.delete();
    d_before = n_done;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_abc", int'({a, b, c}), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_sig", int'(sig), 0);
    repeat (2) @(negedge clk);
    r = 1'b1;
    repeat (50) @(negedge clk);
    chk("abort_no_done", n_done, d_before);
    run_main(0);

    // START held high across FIN
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(mk(0, cyc, 32));
    wait_done(0, 100);
    q.push_back(mk(0, cyc + 2, 32));
    @(posedge clk);
    #1;
    chk("gap_busy", int'(busy), 0);
    chk("gap_done", int'(done), 0);
    @(posedge clk);
    #1;
    chk("restart_busy", int'(busy), 1);
    @(negedge clk) start = 1'b0;
    wait_done(0, 100);

    // SETTLE_CYC=0 instance
    mode = 0;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1;
    q0.push_back(mk(0, cyc, 16));
    @(negedge clk) start0 = 1'b0;
    wait_done(1, 100);

    mode = 2;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1;
    q0.push_back(mk(2, cyc, 16));
    @(negedge clk) start0 = 1'b0;
    wait_done(1, 100);

    repeat (3) @(negedge clk);
    chk("queues_drained", q.size() + q0.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/nand3_bist.md
NAND3_BIST -- requirements
Module: nand3_bist

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, hold cycles per vector between drive and sample (legal 0..15).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port R  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port START  input  1  run request, sampled only in IDLE.
REQ-005 SHALL have ports DUT_A, DUT_B, DUT_C  output  1 each  stimulus driven to the cell under test's A, B, C inputs.
REQ-006 SHALL have port DUT_Y  input  1  response from the cell under test's Y output.
REQ-007 SHALL have port BUSY  output  1  high while the run is in progress.
REQ-008 SHALL have port DONE  output  1  single-cycle end-of-run pulse.
REQ-009 SHALL have port PASS  output  1  last run had zero mismatches; held until the next run starts.
REQ-010 SHALL have port ERR_CNT  output  4  mismatch count of the last run, 0..8.
REQ-011 SHALL have port FIRST_FAIL  output  3  index of the first mismatching vector; 0 when there is none.
REQ-012 SHALL have port SIG  output  8  response signature (see Configuration).

Function
REQ-013 SHALL implement the FSM states IDLE, DRIVE, SETTLE, SAMPLE and FIN; the reset state SHALL be IDLE.
REQ-014 In IDLE, START=1 SHALL move the FSM to DRIVE with vector index V=0 and clear ERR_CNT, FIRST_FAIL and PASS, and load SIG with 0xFF.
REQ-015 SHALL apply vectors in the order V=0..7, mapped as {DUT_A,DUT_B,DUT_C}=V[2:0], with DUT_A as the MSB.
REQ-016 DRIVE SHALL last 1 cycle and apply V; SETTLE SHALL last SETTLE_CYC cycles holding V, and SHALL be skipped when SETTLE_CYC=0; SAMPLE SHALL last 1 cycle and capture DUT_Y at its closing edge.
REQ-017 The expected value SHALL be Y = NOT(A AND B AND C), so Y=0 only when V=7.
REQ-018 On a mismatch, SAMPLE SHALL increment ERR_CNT; FIRST_FAIL SHALL capture V only on the first mismatch of the run.
REQ-019 After SAMPLE, the FSM SHALL go to DRIVE with V+1 when V<7, and to FIN when V=7; V SHALL NOT wrap.
REQ-020 FIN SHALL last 1 cycle, assert DONE, set PASS=(ERR_CNT==0) and then return to IDLE.
REQ-021 BUSY SHALL be 1 in DRIVE, SETTLE and SAMPLE, and 0 in IDLE and FIN.
REQ-022 A run SHALL occupy 8*(SETTLE_CYC+2) BUSY cycles; with SETTLE_CYC=2, DONE SHALL be high in the 33rd cycle after the START-sampling edge.
REQ-023 START SHALL be ignored outside IDLE, including in FIN; holding START high SHALL restart a run one cycle after FIN.
REQ-024 DUT_A/B/C SHALL hold the last applied vector in FIN and in IDLE.
REQ-025 Result outputs (PASS, ERR_CNT, FIRST_FAIL, SIG) SHALL be registered and stable from FIN until the next accepted START.

Reset
REQ-026 R=0 SHALL immediately force, regardless of CLK: FSM to IDLE; V, DUT_A/B/C, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL and SIG all to 0.
REQ-027 R asserted mid-run SHALL abort the run with no DONE pulse and no partial results retained.
REQ-028 After R deasserts, START SHALL be sampled no earlier than the first rising CLK edge.

Configuration
REQ-029 Macro NAND3_BIST_MISR_EN defined SHALL enable an 8-bit MISR on SIG that updates only in SAMPLE.
- fb = SIG[7]^SIG[5]^SIG[4]^SIG[3]
- SIG <= {SIG[6:0], fb^DUT_Y}
- seed 0xFF at run start
REQ-030 Macro NAND3_BIST_MISR_EN undefined SHALL tie SIG to 0x00 with no MISR logic; all other behaviour SHALL be identical.

Verification
REQ-031 Good NAND3 model, SETTLE_CYC=2, 1-cycle START -> DONE in cycle 33, PASS=1, ERR_CNT=0, FIRST_FAIL=0, SIG=0xFE (MISR_EN).
REQ-032 DUT_Y stuck-at-1 -> ERR_CNT=1, FIRST_FAIL=7, PASS=0, SIG=0xFF (MISR_EN).
REQ-033 DUT_Y stuck-at-0 -> ERR_CNT=7, FIRST_FAIL=0, PASS=0.
REQ-034 R pulsed low during V=4 SETTLE -> all outputs 0 within the same cycle and no DONE; a new START then gives the full REQ-031 result.
REQ-035 START held high through the run -> no restart before FIN, a second run begins the cycle after FIN; SETTLE_CYC=0 -> DONE in cycle 17.
REQ-036 Build without NAND3_BIST_MISR_EN, REQ-031 stimulus -> SIG=0x00 throughout, other results unchanged.
